// File: rtl/machine_timer_unit.sv
// machine_timer_unit: CLINT-style machine timer (mtime/mtimecmp) and software
// interrupt (msip) source feeding the CSR unit's interrupt inputs.
//
// Bus handshake: bus_read/bus_write are single-cycle requests with no
// backpressure. Every request is accepted at the rising edge where it is
// seen. A read returns bus_read_data with a one-cycle bus_read_valid pulse
// in the following cycle. Any unmapped or misaligned access, read or write,
// pulses bus_error in that same following cycle.
module machine_timer_unit #(
    parameter int                      DATA_WIDTH   = 64,
    parameter int                      ADDRESS_BITS = 64,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDR    = 64'h0200_0000,
    parameter int                      PRESCALE     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    bus_read,
    input  logic                    bus_write,
    input  logic [ADDRESS_BITS-1:0] bus_address,
    input  logic [DATA_WIDTH-1:0]   bus_write_data,
    output logic [DATA_WIDTH-1:0]   bus_read_data,
    output logic                    bus_read_valid,
    output logic                    bus_error,
    output logic [DATA_WIDTH-1:0]   mtime,
    output logic                    timer_interrupt,
    output logic                    software_interrupt
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    localparam logic [ADDRESS_BITS-1:0] OFF_MSIP     = ADDRESS_BITS'(32'h0000);
    localparam logic [ADDRESS_BITS-1:0] OFF_MTIMECMP = ADDRESS_BITS'(32'h4000);
    localparam logic [ADDRESS_BITS-1:0] OFF_MTIME    = ADDRESS_BITS'(32'hBFF8);

    logic [PCNT_W-1:0]       pcnt;
    logic                    tick;
    logic [DATA_WIDTH-1:0]   mtimecmp;
    logic                    msip;

    logic [ADDRESS_BITS-1:0] offset;
    logic                    aligned;
    logic                    sel_msip;
    logic                    sel_mtimecmp;
    logic                    sel_mtime;
    logic                    mapped;
    logic [DATA_WIDTH-1:0]   read_mux;

    // Addresses below the base wrap to huge offsets, so they never match.
    assign offset       = bus_address - BASE_ADDR;
    assign aligned      = (bus_address[2:0] == 3'b000);
    assign sel_msip     = aligned && (offset == OFF_MSIP);
    assign sel_mtimecmp = aligned && (offset == OFF_MTIMECMP);
    assign sel_mtime    = aligned && (offset == OFF_MTIME);
    assign mapped       = sel_msip || sel_mtimecmp || sel_mtime;

    assign tick = (pcnt == PCNT_LAST);

    // Interrupt levels come straight from the registered values.
    assign timer_interrupt    = (mtime >= mtimecmp);
    assign software_interrupt = msip;

    // Read data selection from pre-edge register values; unmapped reads give 0.
    always_comb begin
        read_mux = '0;
        if (sel_msip) begin
            read_mux = {{(DATA_WIDTH-1){1'b0}}, msip};
        end else if (sel_mtimecmp) begin
            read_mux = mtimecmp;
        end else if (sel_mtime) begin
            read_mux = mtime;
        end
    end

    // Prescaler and mtime counter; a bus write to mtime overrides the tick and restarts the prescaler.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt  <= '0;
            mtime <= '0;
        end else if (bus_write && sel_mtime) begin
            pcnt  <= '0;
            mtime <= bus_write_data;
        end else if (tick) begin
            pcnt  <= '0;
            mtime <= mtime + DATA_WIDTH'(1);
        end else begin
            pcnt  <= pcnt + PCNT_W'(1);
        end
    end

    // Software-written compare and software-interrupt registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (bus_write && sel_mtimecmp) begin
                mtimecmp <= bus_write_data;
            end
            if (bus_write && sel_msip) begin
                msip <= bus_write_data[0];
            end
        end
    end

    // Registered bus response: one-cycle valid and error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_read_data  <= '0;
            bus_read_valid <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            bus_read_valid <= bus_read;
            bus_error      <= (bus_read || bus_write) && !mapped;
            if (bus_read) begin
                bus_read_data <= read_mux;
            end
        end
    end

endmodule
